// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, command/response bytes, error codes and timing defaults
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} ps2_tx_state_e;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  localparam logic [7:0] RSP_ACK = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam int INHIBIT_CYCLES_DEF = 6000;
  localparam int TIMEOUT_CYCLES_DEF = 750000;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NO_ACK = 2'b10;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake plus open-drain PS/2 line levels and drive enables
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic tx_done;
  logic tx_error;
  logic [1:0] err_code;
  logic ps2_clk_in;
  logic ps2_data_in;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    input tx_ready, tx_done, tx_error, err_code, ps2_clk_oe, ps2_data_oe
  );
  modport slave (
    input tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    output tx_ready, tx_done, tx_error, err_code, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchroniser plus falling-edge detect for one PS/2 line
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic sync_o,
  output logic fall_o
);
  logic [2:0] sh_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh_q <= '0;
    else sh_q <= {sh_q[1:0], line_i};
  assign sync_o = sh_q[1];
  assign fall_o = sh_q[2] & ~sh_q[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command sender with clock inhibit, ACK check and timeout
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic clk,
  input logic rst_n,
  ps2_host_tx_if.slave bus
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  ps2_tx_state_e state_q, state_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] to_q, to_d;
  logic [3:0] bit_q, bit_d;
  logic [9:0] sh_q, sh_d;
  logic ack_q, ack_d;
  logic [1:0] code_q;
  logic clk_s, data_s, clk_fall, unused_data_fall;
  logic hs, timeout, lines_idle, done, err;
  logic [1:0] code_now;
  ps2_line_sync u_clk_sync (.clk(clk), .rst_n(rst_n), .line_i(bus.ps2_clk_in), .sync_o(clk_s), .fall_o(clk_fall));
  ps2_line_sync u_data_sync (.clk(clk), .rst_n(rst_n), .line_i(bus.ps2_data_in), .sync_o(data_s), .fall_o(unused_data_fall));
  assign hs = bus.tx_valid && state_q == IDLE;
  assign timeout = (state_q inside {SEND, ACK, WAIT_IDLE}) && to_q == TW'(TIMEOUT_CYCLES);
  assign lines_idle = clk_s & data_s;
  assign done = state_q == WAIT_IDLE && lines_idle && ack_q && !timeout;
  assign err = timeout || (state_q == WAIT_IDLE && lines_idle && !ack_q);
  assign code_now = timeout ? ERR_TIMEOUT : ERR_NO_ACK;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      inh_q <= '0;
      to_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      ack_q <= 1'b0;
      code_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      inh_q <= inh_d;
      to_q <= to_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      ack_q <= ack_d;
      code_q <= err ? code_now : code_q;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = bus.tx_valid ? INHIBIT : IDLE;
      INHIBIT:   state_d = inh_q == IW'(INHIBIT_CYCLES - 1) ? REQ : INHIBIT;
      REQ:       state_d = SEND;
      SEND:      state_d = clk_fall && bit_q == 4'd9 ? ACK : SEND;
      ACK:       state_d = clk_fall ? WAIT_IDLE : ACK;
      WAIT_IDLE: state_d = lines_idle ? IDLE : WAIT_IDLE;
      default:   state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end
  // Frame shifts out LSB first: start (0), d0..d7, parity, stop (1); sh_q[0] is the bit on the line.
  always_comb begin
    inh_d = state_q == INHIBIT ? inh_q + 1'b1 : '0;
    to_d = (state_q inside {SEND, ACK, WAIT_IDLE}) && !clk_fall ? to_q + 1'b1 : '0;
    bit_d = state_q == REQ ? '0 : (state_q == SEND && clk_fall) ? bit_q + 4'd1 : bit_q;
    sh_d = hs ? {1'b1, odd_parity(bus.tx_data), bus.tx_data, 1'b0}
         : (state_q == SEND && clk_fall) ? {1'b1, sh_q[9:1]} : sh_q;
    ack_d = state_q == ACK && clk_fall ? ~data_s : ack_q;
  end
  always_comb begin
    bus.tx_ready = state_q == IDLE;
    bus.ps2_clk_oe = !timeout && (state_q == INHIBIT || state_q == REQ);
    bus.ps2_data_oe = !timeout && (state_q == REQ || (state_q == SEND && !sh_q[0]));
    bus.tx_done = done;
    bus.tx_error = err;
    bus.err_code = err ? code_now : code_q;
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: table-driven frames against an open-drain device model, plus timeout/reset/hold corner cases
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TMO = 500;
  localparam int HALF = 20;
  typedef struct {
    logic [7:0] d;
    logic ack;
    logic par;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  int tests = 0;
  int fails = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;
  logic [1:0] exp_code = 2'b00;
  logic [7:0] sb[$];
  vec_t tbl[6];
  ps2_host_tx_if bus();
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.ps2_clk_in = ~(bus.ps2_clk_oe | dev_clk_low);
  assign bus.ps2_data_in = ~(bus.ps2_data_oe | dev_data_low);
  always @(negedge clk) begin
    if (bus.tx_done) n_done <= n_done + 1;
    if (bus.tx_error) n_err <= n_err + 1;
    if (bus.tx_done && bus.tx_error) n_both <= n_both + 1;
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic start_tx(input logic [7:0] d);
    int t = 0;
    while (!bus.tx_ready && t < 1000) begin
      cyc(1);
      t++;
    end
    chk("ready_before_tx", 32'(bus.tx_ready), 1);
    bus.tx_data = d;
    bus.tx_valid = 1'b1;
    cyc(1);
    bus.tx_valid = 1'b0;
    sb.push_back(d);
  endtask
  task automatic chk_inhibit();
    int n = 0;
    while (bus.ps2_clk_oe && !bus.ps2_data_oe && n < 1000) begin
      n++;
      cyc(1);
    end
    chk("inhibit_len", n, INH);
    chk("req_both_oe", {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b11);
    cyc(1);
    chk("send_entry_oe", {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 2'b01);
  endtask
  task automatic dev_frame(input logic ack, output logic [10:0] rd);
    rd = '0;
    rd[0] = bus.ps2_data_in;
    for (int i = 1; i <= 11; i++) begin
      dev_clk_low = 1'b1;
      cyc(HALF);
      if (i <= 10) rd[i] = bus.ps2_data_in;
      dev_clk_low = 1'b0;
      if (i == 11) dev_data_low = 1'b0;
      cyc(5);
      if (i == 10 && ack) dev_data_low = 1'b1;
      cyc(HALF - 5);
    end
  endtask
  task automatic chk_frame(input logic [10:0] rd, input logic ack, input logic par, input int d0, input int e0);
    logic [7:0] exp_d;
    exp_d = sb.pop_front();
    chk("start_bit", 32'(rd[0]), 0);
    chk("data_bits", 32'(rd[8:1]), 32'(exp_d));
    chk("parity_bit", 32'(rd[9]), 32'(par));
    chk("stop_bit", 32'(rd[10]), 1);
    chk("done_pulses", n_done - d0, ack ? 1 : 0);
    chk("err_pulses", n_err - e0, ack ? 0 : 1);
    if (!ack) exp_code = 2'b10;
    chk("err_code", 32'(bus.err_code), 32'(exp_code));
    chk("ready_after", 32'(bus.tx_ready), 1);
  endtask
  task automatic run_frame(input logic [7:0] d, input logic ack, input logic par);
    logic [10:0] rd;
    int d0, e0;
    d0 = n_done;
    e0 = n_err;
    start_tx(d);
    chk_inhibit();
    cyc(10);
    dev_frame(ack, rd);
    cyc(10);
    chk_frame(rd, ack, par, d0, e0);
  endtask
  initial begin
    logic [10:0] rd;
    int n, d0, e0;
    tbl[0] = '{8'hED, 1'b1, 1'b1};
    tbl[1] = '{8'h07, 1'b1, 1'b0};
    tbl[2] = '{8'hF4, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 1'b1, 1'b1};
    tbl[4] = '{8'h00, 1'b1, 1'b1};
    tbl[5] = '{8'hFE, 1'b0, 1'b0};
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    cyc(3);
    chk("rst_oe", {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
    chk("rst_pulses", {30'd0, bus.tx_done, bus.tx_error}, 0);
    chk("rst_err_code", 32'(bus.err_code), 0);
    rst_n = 1'b1;
    cyc(5);
    chk("ready_idle", 32'(bus.tx_ready), 1);
    for (int i = 0; i < 6; i++) run_frame(tbl[i].d, tbl[i].ack, tbl[i].par);
    // device never clocks
    d0 = n_done;
    start_tx(8'h12);
    chk_inhibit();
    n = 0;
    while (!bus.tx_error && n < 2000) begin
      cyc(1);
      n++;
    end
    chk("timeout_cycles", n, TMO);
    chk("timeout_code", 32'(bus.err_code), 1);
    chk("timeout_oe", {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
    exp_code = 2'b01;
    sb.delete();
    cyc(3);
    chk("timeout_no_done", n_done - d0, 0);
    chk("timeout_ready", 32'(bus.tx_ready), 1);
    chk("timeout_code_hold", 32'(bus.err_code), 32'(exp_code));
    // reset after the 5th fall
    d0 = n_done;
    e0 = n_err;
    start_tx(8'h5A);
    chk_inhibit();
    cyc(10);
    for (int i = 0; i < 4; i++) begin
      dev_clk_low = 1'b1;
      cyc(HALF);
      dev_clk_low = 1'b0;
      cyc(HALF);
    end
    dev_clk_low = 1'b1;
    cyc(5);
    chk("pre_rst_data_oe", 32'(bus.ps2_data_oe), 32'(~8'h5A >> 3) & 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_oe", {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
    chk("rst_mid_pulses", {30'd0, bus.tx_done, bus.tx_error}, 0);
    exp_code = 2'b00;
    chk("rst_mid_code", 32'(bus.err_code), 32'(exp_code));
    cyc(HALF);
    dev_clk_low = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    sb.delete();
    cyc(10);
    chk("rst_mid_no_pulse", (n_done - d0) + (n_err - e0), 0);
    run_frame(8'hFF, 1'b1, 1'b1);
    // tx_valid held with changing tx_data during a frame
    d0 = n_done;
    e0 = n_err;
    start_tx(8'hF4);
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h55;
    chk("busy_not_ready", 32'(bus.tx_ready), 0);
    chk_inhibit();
    bus.tx_data = 8'hAA;
    cyc(10);
    fork
      dev_frame(1'b1, rd);
      begin
        cyc(150);
        bus.tx_data = 8'h3C;
        cyc(150);
        bus.tx_valid = 1'b0;
      end
    join
    cyc(10);
    chk_frame(rd, 1'b1, 1'b0, d0, e0);
    chk("done_err_exclusive", n_both, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
